// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared types and widths for the ID->EX hazard controller
package hazard_stall_ctrl_pkg;

    localparam int ADDR_WIDTH = 5;

    typedef enum logic {
        MEM_NO_WRITE = 1'b0,
        MEM_WRITE    = 1'b1
    } mem_write_signal;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MULT_BUSY = 2'd1,
        FLUSH     = 2'd2
    } hazard_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// rtl/hazard_stall_ctrl_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    // Count increment requests, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != {CNT_WIDTH{1'b1}})) begin
            count_o <= count_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stall/flush control for the ID->EX boundary
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES  = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] reg_1_addr_ID_i,
    input  logic [ADDR_WIDTH-1:0] reg_2_addr_ID_i,
    input  logic                  reg_1_used_ID_i,
    input  logic                  reg_2_used_ID_i,
    input  logic                  mult_ID_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_EX_i,
    input  mem_write_signal       write_en_EX_i,
    input  logic                  mem_read_EX_i,
    input  logic                  branch_taken_EX_i,
    output logic                  stall_IF_o,
    output logic                  stall_ID_o,
    output logic                  hold_EX_o,
    output logic                  bubble_EX_o,
    output logic                  flush_IF_ID_o,
    output logic                  mult_busy_o,
    output logic [CNT_WIDTH-1:0]  stall_count_o
);

    // Multiply and flush never overlap, so one down-counter serves both.
    localparam int DCNT_MAX = max_int(MULT_CYCLES, FLUSH_CYCLES + 1);
    localparam int DCNT_W   = $clog2(DCNT_MAX);

    hazard_state_t     state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              load_use;

    assign load_use = mem_read_EX_i && (write_en_EX_i == MEM_WRITE) &&
                      ((reg_1_used_ID_i && (reg_1_addr_ID_i == reg_dest_EX_i)) ||
                       (reg_2_used_ID_i && (reg_2_addr_ID_i == reg_dest_EX_i)));

    // Next state and control outputs; reset forces every control output low.
    always_comb begin
        state_d       = state_q;
        dcnt_d        = dcnt_q;
        stall_IF_o    = 1'b0;
        stall_ID_o    = 1'b0;
        hold_EX_o     = 1'b0;
        bubble_EX_o   = 1'b0;
        flush_IF_ID_o = 1'b0;
        mult_busy_o   = 1'b0;
        if (!rst_i) begin
            case (state_q)
                RUN: begin
                    if (branch_taken_EX_i) begin
                        flush_IF_ID_o = 1'b1;
                        bubble_EX_o   = 1'b1;
                        if (FLUSH_CYCLES > 0) begin
                            state_d = FLUSH;
                            dcnt_d  = DCNT_W'(FLUSH_CYCLES);
                        end
                    end else if (load_use) begin
                        stall_IF_o  = 1'b1;
                        stall_ID_o  = 1'b1;
                        bubble_EX_o = 1'b1;
                    end else if (mult_ID_i) begin
                        state_d = MULT_BUSY;
                        dcnt_d  = DCNT_W'(MULT_CYCLES - 1);
                    end
                end
                MULT_BUSY: begin
                    stall_IF_o  = 1'b1;
                    stall_ID_o  = 1'b1;
                    hold_EX_o   = 1'b1;
                    mult_busy_o = 1'b1;
                    dcnt_d      = dcnt_q - DCNT_W'(1);
                    if (dcnt_q == DCNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    flush_IF_ID_o = 1'b1;
                    if (branch_taken_EX_i) begin
                        dcnt_d = DCNT_W'(FLUSH_CYCLES);
                    end else begin
                        dcnt_d = dcnt_q - DCNT_W'(1);
                        if (dcnt_q == DCNT_W'(1)) begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                    dcnt_d  = '0;
                end
            endcase
        end
    end

    // State and down-counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (stall_IF_o),
        .clr_i  (1'b0),
        .count_o(stall_count_o)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed and randomized checks of hazard_stall_ctrl against a cycle model
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    localparam int MC = 4;
    localparam int FC = 1;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [ADDR_WIDTH-1:0] r1, r2, rd;
    logic                  u1, u2, mult, mem_read, br;
    mem_write_signal       we;
    logic                  stall_if, stall_id, hold_ex, bubble_ex, flush_ifid, mult_busy;
    logic [CW-1:0]         stall_count;

    hazard_stall_ctrl #(
        .MULT_CYCLES (MC),
        .FLUSH_CYCLES(FC),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .reg_1_addr_ID_i  (r1),
        .reg_2_addr_ID_i  (r2),
        .reg_1_used_ID_i  (u1),
        .reg_2_used_ID_i  (u2),
        .mult_ID_i        (mult),
        .reg_dest_EX_i    (rd),
        .write_en_EX_i    (we),
        .mem_read_EX_i    (mem_read),
        .branch_taken_EX_i(br),
        .stall_IF_o       (stall_if),
        .stall_ID_o       (stall_id),
        .hold_EX_o        (hold_ex),
        .bubble_EX_o      (bubble_ex),
        .flush_IF_ID_o    (flush_ifid),
        .mult_busy_o      (mult_busy),
        .stall_count_o    (stall_count)
    );

    int errors = 0;
    int checks = 0;

    // Model: remaining multiply-stall cycles, remaining post-branch flush cycles, stall total.
    int m_mult_left  = 0;
    int m_flush_left = 0;
    int m_count      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; r1 = '0; r2 = '0; rd = '0; u1 = 1'b0; u2 = 1'b0;
        mult = 1'b0; mem_read = 1'b0; br = 1'b0; we = MEM_NO_WRITE;
    endtask

    task automatic set_load_use(input logic [ADDR_WIDTH-1:0] reg_n);
        set_idle();
        rd = reg_n; r2 = reg_n; u2 = 1'b1; r1 = reg_n + 5'd1; u1 = 1'b1;
        mem_read = 1'b1; we = MEM_WRITE;
    endtask

    // Called at a falling edge with inputs applied; checks this cycle, advances the model.
    task automatic cycle();
        bit e_sif, e_sid, e_hold, e_bub, e_fl, e_busy, lu;
        #1;
        lu = mem_read && (we == MEM_WRITE) &&
             ((u1 && (r1 == rd)) || (u2 && (r2 == rd)));
        e_sif = 0; e_sid = 0; e_hold = 0; e_bub = 0; e_fl = 0; e_busy = 0;
        if (rst) begin
        end else if (m_mult_left > 0) begin
            e_sif = 1; e_sid = 1; e_hold = 1; e_busy = 1;
        end else if (m_flush_left > 0) begin
            e_fl = 1;
        end else if (br) begin
            e_fl = 1; e_bub = 1;
        end else if (lu) begin
            e_sif = 1; e_sid = 1; e_bub = 1;
        end
        check("stall_IF",    32'(stall_if),    32'(e_sif));
        check("stall_ID",    32'(stall_id),    32'(e_sid));
        check("hold_EX",     32'(hold_ex),     32'(e_hold));
        check("bubble_EX",   32'(bubble_ex),   32'(e_bub));
        check("flush_IF_ID", 32'(flush_ifid),  32'(e_fl));
        check("mult_busy",   32'(mult_busy),   32'(e_busy));
        check("stall_count", 32'(stall_count), 32'(m_count));
        if (rst) begin
            m_mult_left = 0; m_flush_left = 0; m_count = 0;
        end else begin
            if (m_mult_left > 0)       m_mult_left--;
            else if (m_flush_left > 0) m_flush_left = br ? FC : m_flush_left - 1;
            else if (br)               m_flush_left = FC;
            else if (!lu && mult)      m_mult_left = MC - 1;
            if (e_sif && m_count < CNT_MAX) m_count++;
        end
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        check("reset_count", 32'(stall_count), 32'd0);

        // Load to r3 consumed via reg_2: single stall cycle.
        set_load_use(5'd3);
        cycle();
        set_idle();
        cycle();
        check("lu_count", 32'(stall_count), 32'd1);

        // Near misses: unused source, non-writing load, not a load.
        set_load_use(5'd3); u2 = 1'b0; cycle();
        set_load_use(5'd3); we = MEM_NO_WRITE; cycle();
        set_load_use(5'd3); mem_read = 1'b0; cycle();
        set_load_use(5'd3); r2 = 5'd19; cycle();

        // Multiply: three busy cycles, branch pulse mid-busy ignored.
        set_idle(); mult = 1'b1; cycle();
        set_idle(); cycle();
        #1 check("mult_busy_mid", 32'(mult_busy), 32'd1);
        br = 1'b1; cycle();
        br = 1'b0; cycle();
        #1 check("mult_done", 32'(mult_busy), 32'd0);
        check("mult_count", 32'(stall_count), 32'd4);
        cycle();

        // Branch beats load-use and multiply in the same cycle.
        set_load_use(5'd7); mult = 1'b1; br = 1'b1; cycle();
        br = 1'b0; cycle();
        set_idle(); cycle();
        cycle();
        check("br_count", 32'(stall_count), 32'd4);

        // Reset during the second multiply-busy cycle.
        set_idle(); mult = 1'b1; cycle();
        set_idle(); cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; cycle();
        check("rst_count", 32'(stall_count), 32'd0);
        set_load_use(5'd9); cycle();
        set_idle(); cycle();
        check("post_rst_count", 32'(stall_count), 32'd1);

        // Twenty back-to-back load-use stalls saturate the 4-bit counter.
        set_load_use(5'd12);
        for (int i = 0; i < 20; i++) cycle();
        set_idle(); cycle();
        check("sat_count", 32'(stall_count), 32'd15);

        // Randomized traffic with narrow register range to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 79) == 0);
            r1       = ADDR_WIDTH'($urandom_range(0, 3));
            r2       = ADDR_WIDTH'($urandom_range(0, 3));
            rd       = ADDR_WIDTH'($urandom_range(0, 3));
            u1       = 1'($urandom_range(0, 1));
            u2       = 1'($urandom_range(0, 1));
            mult     = ($urandom_range(0, 5) == 0);
            mem_read = 1'($urandom_range(0, 1));
            br       = ($urandom_range(0, 7) == 0);
            we       = mem_write_signal'($urandom_range(0, 1));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
